uart_receiver: RTL and testbench

Asynchronous serial receiver, 8-E-1 framing: start bit, 8 data bits LSB first, even parity, one stop bit. It sits between the board's RxD pin and the consumer logic on the 50 MHz system clock. The line is oversampled at 16x the selected baud rate, and the block reports the received byte with valid, parity-error and framing-error flags.

---
 rtl/uart_pkg.sv | 10 +
 rtl/baud_controller.sv | 28 ++
 rtl/uart_receiver.sv | 99 +++++++++
 tb/tb_uart_receiver.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and types for the UART blocks
package uart_pkg;
  localparam int OSR   = 16;
  localparam int MID   = 8;
  localparam int DIV_W = 14;
  localparam logic [DIV_W-1:0] BAUD_DIV [8] = '{
    14'd10417, 14'd2604, 14'd651, 14'd326, 14'd163, 14'd81, 14'd54, 14'd27
  };
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_e;
endpackage

// File: rtl/baud_controller.sv
// baud_controller: 16x oversample tick generator, phase-resettable by clear
module baud_controller
  import uart_pkg::*;
(
  input  logic       Clk,
  input  logic       reset,
  input  logic [2:0] baud_select,
  input  logic       clear,
  output logic       sample_ENABLE
);
  logic [DIV_W-1:0] cnt_q, cnt_d, div;
  logic [2:0]       sel_q;
  logic             reload;
  assign div           = BAUD_DIV[baud_select];
  assign reload        = clear || (sel_q != baud_select);
  assign sample_ENABLE = !reload && (cnt_q == div - 14'd1);
  // counter restarts on clear, rate change or terminal count
  always_comb cnt_d = (reload || sample_ENABLE) ? '0 : cnt_q + 14'd1;
  // divider state and last seen rate code
  always_ff @(posedge Clk or negedge reset)
    if (!reset) begin
      cnt_q <= '0;
      sel_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      sel_q <= baud_select;
    end
endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 8-E-1 serial receiver with parity/framing error flags
module uart_receiver
  import uart_pkg::*;
(
  input  logic       Clk,
  input  logic       reset,
  input  logic       RxD,
  input  logic       Rx_EN,
  input  logic [2:0] baud_select,
  output logic       Rx_PERROR,
  output logic       Rx_FERROR,
  output logic       Rx_VALID,
  output logic [7:0] Rx_DATA
);
  localparam logic [3:0] TICK_MID = 4'(MID - 1);
  localparam logic [3:0] TICK_END = 4'(OSR - 1);
  rx_state_e  state_q;
  logic [1:0] sync_q;
  logic [3:0] tick_q;
  logic [2:0] bit_q;
  logic [7:0] shift_q, data_q;
  logic       par_q, brk_q, valid_q, perr_q, ferr_q;
  logic       rxd_s, clear, sample_ENABLE, mid, bound, perr_d;
  assign rxd_s     = sync_q[1];
  assign clear     = (state_q == IDLE);
  assign mid       = sample_ENABLE && (tick_q == TICK_MID);
  assign bound     = sample_ENABLE && (tick_q == TICK_END);
  assign perr_d    = ^{shift_q, par_q};
  assign Rx_DATA   = data_q;
  assign Rx_VALID  = valid_q;
  assign Rx_PERROR = perr_q;
  assign Rx_FERROR = ferr_q;
  baud_controller u_baud (
    .Clk           (Clk),
    .reset         (reset),
    .baud_select   (baud_select),
    .clear         (clear),
    .sample_ENABLE (sample_ENABLE)
  );
  // two-flop synchronizer for the asynchronous line, idles high
  always_ff @(posedge Clk or negedge reset)
    if (!reset) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], RxD};
  // frame sequencer with registered results
  always_ff @(posedge Clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      brk_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else if (!Rx_EN) begin
      state_q <= IDLE;
    end else begin
      if (sample_ENABLE) tick_q <= tick_q + 4'd1;
      case (state_q)
        IDLE: begin
          if (brk_q && rxd_s) brk_q <= 1'b0;
          if (!brk_q && !rxd_s) begin
            state_q <= START;
            tick_q  <= '0;
            bit_q   <= '0;
          end
        end
        START: begin
          if (mid && rxd_s) state_q <= IDLE;
          else if (mid) begin
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
          end
          if (bound) state_q <= DATA;
        end
        DATA: if (mid) begin
          shift_q <= {rxd_s, shift_q[7:1]};
          bit_q   <= bit_q + 3'd1;
          if (bit_q == 3'd7) state_q <= PARITY;
        end
        PARITY: if (mid) begin
          par_q   <= rxd_s;
          state_q <= STOP;
        end
        STOP: if (mid) begin
          data_q  <= shift_q;
          perr_q  <= perr_d;
          ferr_q  <= !rxd_s;
          valid_q <= !perr_d && rxd_s;
          brk_q   <= !rxd_s;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: table-driven and scoreboard checks of the 8-E-1 receiver
`timescale 1ns/1ps
module tb_uart_receiver;
  localparam int BIT_HI  = 8680;
  localparam int BIT_MID = 17361;
  localparam int BOUND   = 30000;
  typedef struct packed {logic [7:0] d; logic v; logic p; logic f;} exp_t;
  typedef struct {logic [7:0] d; bit flip; bit stop; exp_t e;} vec_t;
  logic       Clk = 1'b0;
  logic       reset, RxD, Rx_EN;
  logic [2:0] baud_select;
  logic       Rx_PERROR, Rx_FERROR, Rx_VALID;
  logic [7:0] Rx_DATA;
  int         total = 0;
  int         bad = 0;
  exp_t       q[$];
  exp_t       last;
  vec_t       tbl [6];
  uart_receiver dut (
    .Clk         (Clk),
    .reset       (reset),
    .RxD         (RxD),
    .Rx_EN       (Rx_EN),
    .baud_select (baud_select),
    .Rx_PERROR   (Rx_PERROR),
    .Rx_FERROR   (Rx_FERROR),
    .Rx_VALID    (Rx_VALID),
    .Rx_DATA     (Rx_DATA)
  );
  always #10 Clk = ~Clk;
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic chk_all(input string name, input exp_t e);
    chk({name, ".data"}, Rx_DATA, e.d);
    chk({name, ".valid"}, {7'd0, Rx_VALID}, {7'd0, e.v});
    chk({name, ".perr"}, {7'd0, Rx_PERROR}, {7'd0, e.p});
    chk({name, ".ferr"}, {7'd0, Rx_FERROR}, {7'd0, e.f});
  endtask
  task automatic send(input logic [7:0] d, input bit flip, input bit stop, input int bns,
                      input int tail, input logic idle);
    RxD = 1'b0;
    #(bns);
    for (int i = 0; i < 8; i++) begin
      RxD = d[i];
      #(bns);
    end
    RxD = ^d ^ flip;
    #(bns);
    RxD = stop;
    #(bns);
    RxD = idle;
    #(bns * tail);
  endtask
  task automatic collect(input string name);
    int n;
    exp_t e;
    n = 0;
    @(negedge Clk);
    while ((Rx_VALID || Rx_PERROR || Rx_FERROR) && n < BOUND) begin
      @(negedge Clk);
      n++;
    end
    while (!(Rx_VALID || Rx_PERROR || Rx_FERROR) && n < BOUND) begin
      @(negedge Clk);
      n++;
    end
    if (n >= BOUND) begin
      total++;
      bad++;
      $display("FAIL %s: no result within %0d cycles", name, BOUND);
    end
    if (q.size() > 0) begin
      e = q.pop_front();
      chk_all(name, e);
      last = e;
    end
  endtask
  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    reset = 1'b0;
    RxD = 1'b1;
    Rx_EN = 1'b0;
    baud_select = 3'b111;
    #10 reset = 1'b1;
    @(negedge Clk);
    chk_all("reset", '{8'h00, 1'b0, 1'b0, 1'b0});
    Rx_EN = 1'b1;
    #100000;
    @(negedge Clk);
    chk_all("idle", '{8'h00, 1'b0, 1'b0, 1'b0});
    tbl[0] = '{8'h2B, 1'b0, 1'b1, '{8'h2B, 1'b1, 1'b0, 1'b0}};
    tbl[1] = '{8'h2B, 1'b1, 1'b1, '{8'h2B, 1'b0, 1'b1, 1'b0}};
    tbl[2] = '{8'h2B, 1'b0, 1'b0, '{8'h2B, 1'b0, 1'b0, 1'b1}};
    tbl[3] = '{8'h80, 1'b0, 1'b1, '{8'h80, 1'b1, 1'b0, 1'b0}};
    tbl[4] = '{8'hC3, 1'b1, 1'b0, '{8'hC3, 1'b0, 1'b1, 1'b1}};
    tbl[5] = '{8'h7E, 1'b0, 1'b1, '{8'h7E, 1'b1, 1'b0, 1'b0}};
    for (int i = 0; i < 6; i++) begin
      q.push_back(tbl[i].e);
      fork
        send(tbl[i].d, tbl[i].flip, tbl[i].stop, BIT_HI, 1, 1'b1);
        collect($sformatf("vec%0d", i));
      join
    end
    RxD = 1'b0;
    #3000;
    RxD = 1'b1;
    repeat (600) @(negedge Clk);
    chk_all("glitch", last);
    fork
      send(8'h55, 1'b0, 1'b1, BIT_HI, 1, 1'b1);
      begin
        #(BIT_HI * 5);
        Rx_EN = 1'b0;
      end
    join
    Rx_EN = 1'b1;
    repeat (50) @(negedge Clk);
    chk_all("abort", '{last.d, 1'b0, 1'b0, 1'b0});
    q.push_back('{8'h2B, 1'b0, 1'b0, 1'b1});
    fork
      send(8'h2B, 1'b0, 1'b0, BIT_HI, 1, 1'b0);
      collect("brk_frame");
    join
    #(BIT_HI * 4);
    @(negedge Clk);
    chk_all("brk_hold", '{8'h2B, 1'b0, 1'b0, 1'b1});
    RxD = 1'b1;
    #(BIT_HI);
    q.push_back('{8'h55, 1'b1, 1'b0, 1'b0});
    fork
      send(8'h55, 1'b0, 1'b1, BIT_HI, 1, 1'b1);
      collect("after_brk");
    join
    baud_select = 3'b110;
    repeat (10) @(negedge Clk);
    q.push_back('{8'h00, 1'b1, 1'b0, 1'b0});
    q.push_back('{8'hFF, 1'b1, 1'b0, 1'b0});
    fork
      begin
        send(8'h00, 1'b0, 1'b1, BIT_MID, 0, 1'b1);
        send(8'hFF, 1'b0, 1'b1, BIT_MID, 1, 1'b1);
      end
      begin
        collect("b2b0");
        collect("b2b1");
      end
    join
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
